// File: rtl/lvds_frame_tx.sv
// lvds_frame_tx
//   Builds framed image lines for the LVDS transmit path, one 16-bit word
//   every WORD_DIV clk40M cycles. Each line is FFFF, FFFF, AAAA, 16 pixels,
//   then GAP_WORDS zero words. Pixels come either from an upstream
//   valid/consume source (mode=0) or from an internal 16-bit ramp (mode=1).
//
// Parameters
//   WORD_DIV  : clk40M cycles per output word (2..255)
//   GAP_WORDS : zero words after the last pixel of each line (1..255)
//
// Ports
//   clk40M   in   system clock
//   nRst     in   asynchronous active-low reset
//   start    in   one-cycle frame request, dropped while busy
//   mode     in   pixel source, sampled with start (0 stream, 1 ramp)
//   numLines in   lines per frame, sampled with start
//   pixIn    in   upstream pixel word
//   pixValid in   pixIn holds a valid pixel
//   pixRd    out  consume pulse; pixIn is taken in this cycle
//   txData   out  word presented to the serializer
//   txStrobe out  word tick; txData takes its next word at the end of this cycle
//   busy     out  frame in progress
//   done     out  one-cycle pulse on the final tick of a frame
//   underrun out  sticky: a stream pixel slot found no valid data
module lvds_frame_tx #(
    parameter int WORD_DIV  = 40,
    parameter int GAP_WORDS = 4
) (
    input  logic        clk40M,
    input  logic        nRst,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  numLines,
    input  logic [15:0] pixIn,
    input  logic        pixValid,
    output logic        pixRd,
    output logic [15:0] txData,
    output logic        txStrobe,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam logic [15:0] PREAMBLE_WORD = 16'hFFFF;
    localparam logic [15:0] SYNC_WORD     = 16'hAAAA;
    localparam logic [7:0]  DIV_LAST      = 8'(WORD_DIV - 1);
    localparam logic [7:0]  GAP_LAST      = 8'(GAP_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE0,
        S_PRE1,
        S_SYNC,
        S_PIXEL,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  div_cnt;
    logic        tick;
    logic [3:0]  pix_idx;
    logic [7:0]  gap_cnt;
    logic [7:0]  lines_left;
    logic        ramp_mode;
    logic [15:0] ramp_cnt;

    logic        start_ok;
    logic        load_pixel;
    logic        end_frame;
    logic [15:0] word_next;

    // Free-running word-rate divider; it keeps ticking in IDLE so the
    // serializer always sees a constant word rate.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign tick     = (div_cnt == DIV_LAST);
    assign txStrobe = tick;

    // A start is only taken while fully idle; one arriving mid-frame is lost.
    assign start_ok = start && (state == S_IDLE) && !busy;

    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-word decode; everything advances only on a tick.
    // txData is registered, so the word chosen here shows up on txData right
    // after the tick edge and is held until the following tick.
    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        word_next  = 16'h0000;
        load_pixel = 1'b0;
        end_frame  = 1'b0;

        if (tick) begin
            case (state)
                S_IDLE: begin
                    // busy set with state still IDLE means a start is pending.
                    if (busy) begin
                        if (lines_left != 8'd0) begin
                            state_next = S_PRE0;
                            word_next  = PREAMBLE_WORD;
                        end else begin
                            end_frame = 1'b1;
                        end
                    end
                end
                S_PRE0: begin
                    state_next = S_PRE1;
                    word_next  = PREAMBLE_WORD;
                end
                S_PRE1: begin
                    state_next = S_SYNC;
                    word_next  = SYNC_WORD;
                end
                S_SYNC: begin
                    state_next = S_PIXEL;
                    load_pixel = 1'b1;
                end
                S_PIXEL: begin
                    // pix_idx counts the pixels still to come in this line.
                    if (pix_idx != 4'd0) begin
                        load_pixel = 1'b1;
                    end else begin
                        state_next = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        if (lines_left > 8'd1) begin
                            state_next = S_PRE0;
                            word_next  = PREAMBLE_WORD;
                        end else begin
                            state_next = S_IDLE;
                            end_frame  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        // A missing stream pixel goes out as zero: the receiver has no flow
        // control, so the line length must never change.
        if (load_pixel) begin
            if (ramp_mode) begin
                word_next = ramp_cnt;
            end else if (pixValid) begin
                word_next = pixIn;
            end else begin
                word_next = 16'h0000;
            end
        end
    end

    assign pixRd = load_pixel && !ramp_mode && pixValid;
    assign done  = end_frame;

    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            txData     <= '0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            ramp_mode  <= 1'b0;
            lines_left <= '0;
            ramp_cnt   <= '0;
            pix_idx    <= '0;
            gap_cnt    <= '0;
        end else begin
            if (start_ok) begin
                busy       <= 1'b1;
                ramp_mode  <= mode;
                lines_left <= numLines;
                underrun   <= 1'b0;
                ramp_cnt   <= '0;
            end

            if (tick) begin
                txData <= word_next;

                if (state == S_SYNC) begin
                    pix_idx <= 4'd15;
                end else if (state == S_PIXEL) begin
                    pix_idx <= pix_idx - 4'd1;
                end

                if ((state == S_PIXEL) && (state_next == S_GAP)) begin
                    gap_cnt <= GAP_LAST;
                end else if ((state == S_GAP) && (gap_cnt != 8'd0)) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end

                if ((state == S_GAP) && (state_next == S_PRE0)) begin
                    lines_left <= lines_left - 8'd1;
                end

                if (end_frame) begin
                    busy <= 1'b0;
                end
            end

            // The ramp runs on across lines and wraps naturally at 16 bits.
            if (load_pixel) begin
                if (ramp_mode) begin
                    ramp_cnt <= ramp_cnt + 16'd1;
                end else if (!pixValid) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lvds_frame_tx.sv
// Testbench for lvds_frame_tx: table of frame requests, each expanded into an
// expected word stream (scoreboard queue) and compared word by word as the DUT
// emits it, plus hand-written idle and mid-frame reset sequences.
module tb_lvds_frame_tx;

    localparam int WD  = 40;
    localparam int GW  = 4;
    localparam int WPL = 19 + GW;   // words per line

    logic        clk40M;
    logic        nRst;
    logic        start;
    logic        mode;
    logic [7:0]  numLines;
    logic [15:0] pixIn;
    logic        pixValid;
    logic        pixRd;
    logic [15:0] txData;
    logic        txStrobe;
    logic        busy;
    logic        done;
    logic        underrun;

    lvds_frame_tx #(
        .WORD_DIV  (WD),
        .GAP_WORDS (GW)
    ) dut (
        .clk40M   (clk40M),
        .nRst     (nRst),
        .start    (start),
        .mode     (mode),
        .numLines (numLines),
        .pixIn    (pixIn),
        .pixValid (pixValid),
        .pixRd    (pixRd),
        .txData   (txData),
        .txStrobe (txStrobe),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    initial clk40M = 1'b0;
    always #10 clk40M = ~clk40M;

    typedef struct {
        logic        mode;
        logic [7:0]  lines;
        int          drop_a;     // pixel slot (0..15) with pixValid low, -1 none
        int          drop_b;
        logic [15:0] base;       // first upstream pixel value
        int          mid_start;  // cycle of an extra start inside the frame, 0 none
        int          exp_rd;     // expected pixRd pulses
        logic        exp_under;  // expected underrun at frame end
    } vec_t;

    int          n_vec;
    int          n_bad;

    logic [15:0] exp_q[$];
    int          frame_words;
    int          rd_count;
    int          done_count;
    int          drop_a;
    int          drop_b;
    logic [15:0] pix_src;
    bit          pend_word;
    bit          pend_rd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: a word belongs to the frame when it is launched by a tick with
    // busy high and done low; it is visible on txData one negedge later.
    always @(negedge clk40M) begin
        if (!nRst) begin
            pend_word = 1'b0;
            pend_rd   = 1'b0;
        end else begin
            if (pend_rd) begin
                pix_src = pix_src + 16'd1;
            end
            if (pend_word) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL extra_word: got %h after %0d words, expected none", txData, frame_words);
                end else begin
                    check($sformatf("word%0d", frame_words), {16'h0, txData}, {16'h0, exp_q.pop_front()});
                end
                frame_words++;
            end
            if (pixRd) rd_count++;
            if (done) done_count++;
            pend_word = txStrobe && busy && !done;
            pend_rd   = pixRd;
            pixIn     = pix_src;
            begin
                int pos;
                int slot;
                pos  = frame_words % WPL;
                slot = pos - 3;
                pixValid = !((pos >= 3) && (pos < 19) && ((slot == drop_a) || (slot == drop_b)));
            end
        end
    end

    // Called at a negedge: builds the expected stream and pulses start.
    task automatic start_frame(input vec_t v);
        logic [15:0] src;
        logic [15:0] ramp;
        exp_q.delete();
        frame_words = 0;
        rd_count    = 0;
        done_count  = 0;
        drop_a      = v.drop_a;
        drop_b      = v.drop_b;
        pix_src     = v.base;
        pixIn       = v.base;
        pixValid    = 1'b1;
        src  = v.base;
        ramp = 16'h0000;
        for (int l = 0; l < int'(v.lines); l++) begin
            exp_q.push_back(16'hFFFF);
            exp_q.push_back(16'hFFFF);
            exp_q.push_back(16'hAAAA);
            for (int s = 0; s < 16; s++) begin
                if (v.mode) begin
                    exp_q.push_back(ramp);
                    ramp = ramp + 16'd1;
                end else if ((s == v.drop_a) || (s == v.drop_b)) begin
                    exp_q.push_back(16'h0000);
                end else begin
                    exp_q.push_back(src);
                    src = src + 16'd1;
                end
            end
            for (int g = 0; g < GW; g++) exp_q.push_back(16'h0000);
        end
        mode     = v.mode;
        numLines = v.lines;
        start    = 1'b1;
        @(negedge clk40M);
        start = 1'b0;
        check("underrun_clr", {31'h0, underrun}, 32'h0);
        check("busy_rise", {31'h0, busy}, 32'h1);
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int first_ff;
        int busy_cyc;
        int budget;
        start_frame(v);
        k        = 0;
        first_ff = -1;
        busy_cyc = 1;
        budget   = (int'(v.lines) * WPL + 3) * WD + 100;
        while ((done_count == 0) && (k < budget)) begin
            @(negedge clk40M);
            k++;
            if ((first_ff < 0) && (txData == 16'hFFFF)) first_ff = k;
            if (busy) busy_cyc++;
            if ((v.mid_start != 0) && (k == v.mid_start)) begin
                start    = 1'b1;
                numLines = 8'd9;
                mode     = ~v.mode;
            end
            if ((v.mid_start != 0) && (k == v.mid_start + 1)) start = 1'b0;
        end
        if (done_count == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected one", budget);
        end
        repeat (2) @(negedge clk40M);
        if (v.lines != 8'd0) begin
            check("first_ff_latency_ok", {31'h0, (first_ff > 0) && (first_ff <= WD + 1)}, 32'h1);
        end else begin
            check("zero_line_busy_ok", {31'h0, busy_cyc <= WD + 1}, 32'h1);
        end
        check("words_left", exp_q.size(), 32'h0);
        check("frame_words", frame_words, int'(v.lines) * WPL);
        check("pixrd_count", rd_count, v.exp_rd);
        check("done_count", done_count, 32'h1);
        check("underrun_end", {31'h0, underrun}, {31'h0, v.exp_under});
        check("busy_end", {31'h0, busy}, 32'h0);
        // A dropped start must not come back as a queued frame.
        repeat (3 * WD) @(negedge clk40M);
        check("busy_stays_low", {31'h0, busy}, 32'h0);
        check("no_extra_done", done_count, 32'h1);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t rv;
        int   strobes;
        int   last;
        int   bad_int;
        int   idle_bad;
        int   k;

        vecs[0] = '{mode: 1'b0, lines: 8'd1, drop_a: -1, drop_b: -1, base: 16'h0100, mid_start: 0,   exp_rd: 16, exp_under: 1'b0};
        vecs[1] = '{mode: 1'b1, lines: 8'd3, drop_a: -1, drop_b: -1, base: 16'h0000, mid_start: 0,   exp_rd: 0,  exp_under: 1'b0};
        vecs[2] = '{mode: 1'b0, lines: 8'd1, drop_a: 5,  drop_b: 6,  base: 16'h0200, mid_start: 0,   exp_rd: 14, exp_under: 1'b1};
        vecs[3] = '{mode: 1'b1, lines: 8'd0, drop_a: -1, drop_b: -1, base: 16'h0000, mid_start: 0,   exp_rd: 0,  exp_under: 1'b0};
        vecs[4] = '{mode: 1'b0, lines: 8'd2, drop_a: -1, drop_b: -1, base: 16'h0300, mid_start: 0,   exp_rd: 32, exp_under: 1'b0};
        vecs[5] = '{mode: 1'b1, lines: 8'd1, drop_a: -1, drop_b: -1, base: 16'h0000, mid_start: 300, exp_rd: 0,  exp_under: 1'b0};

        n_vec       = 0;
        n_bad       = 0;
        frame_words = 0;
        rd_count    = 0;
        done_count  = 0;
        drop_a      = -1;
        drop_b      = -1;
        pix_src     = 16'h0000;
        pend_word   = 1'b0;
        pend_rd     = 1'b0;
        nRst        = 1'b0;
        start       = 1'b0;
        mode        = 1'b0;
        numLines    = 8'd0;
        pixIn       = 16'h0000;
        pixValid    = 1'b0;

        #1;
        check("rst_txdata", {16'h0, txData}, 32'h0);
        check("rst_strobe", {31'h0, txStrobe}, 32'h0);
        check("rst_pixrd", {31'h0, pixRd}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);

        repeat (3) @(negedge clk40M);
        nRst = 1'b1;

        // Idle: strobe every WD cycles, txData zero, busy low.
        strobes  = 0;
        last     = -1;
        bad_int  = 0;
        idle_bad = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk40M);
            if (txStrobe) begin
                strobes++;
                if ((last >= 0) && (i - last != WD)) bad_int++;
                last = i;
            end
            if ((txData != 16'h0000) || busy) idle_bad++;
        end
        check("idle_strobes", strobes, 32'd5);
        check("idle_strobe_interval_errs", bad_int, 32'd0);
        check("idle_output_errs", idle_bad, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during PIXEL of line 2, with underrun already set by line 1.
        rv = '{mode: 1'b0, lines: 8'd2, drop_a: 2, drop_b: -1, base: 16'h0400, mid_start: 0, exp_rd: 0, exp_under: 1'b1};
        start_frame(rv);
        k = 0;
        while ((frame_words < WPL + 8) && (k < 3 * WPL * WD)) begin
            @(negedge clk40M);
            k++;
        end
        check("reached_line2_pixel", {31'h0, frame_words >= WPL + 8}, 32'h1);
        check("underrun_pre_reset", {31'h0, underrun}, 32'h1);
        check("busy_pre_reset", {31'h0, busy}, 32'h1);
        #3 nRst = 1'b0;
        #1;
        check("midrst_txdata", {16'h0, txData}, 32'h0);
        check("midrst_strobe", {31'h0, txStrobe}, 32'h0);
        check("midrst_pixrd", {31'h0, pixRd}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_underrun", {31'h0, underrun}, 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk40M);
        nRst = 1'b1;
        @(negedge clk40M);

        // Clean frame after the reset: scoreboard expects a fresh preamble.
        rv = '{mode: 1'b1, lines: 8'd1, drop_a: -1, drop_b: -1, base: 16'h0000, mid_start: 0, exp_rd: 0, exp_under: 1'b0};
        run_vec(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
